// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, oversampled start/data/parity/stop FSM, FWFT byte FIFO, registered RTS.
// Latency: byte on rx_d_o one cycle after the mid-stop sample; FIFO full with no pop drops the byte (overrun).

module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_vld_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_rdy_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             pop_ok, push_ok;

  assign count_o    = wptr_q - rptr_q;
  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_dat_o = mem_q[rptr_q[AW-1:0]];
  assign pop_ok     = pop_rdy_i && !empty_o;
  assign push_ok    = push_vld_i && (!full_o || pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wptr_q[AW-1:0]] <= push_dat_i;
    end
  end
endmodule

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 rx_enable_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 flush_i,
  output logic                 rx_rts_n_o,
  output logic [7:0]           rx_d_o,
  output logic                 rx_d_valid_o,
  input  logic                 rx_d_ready_i,
  output logic                 rx_full_o,
  output logic                 rx_empty_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OSW-1:0]       OS_HALF = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0]       OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0]       OS_ONE  = OSW'(1);
  localparam logic [CW-1:0]        RTS_LVL = CW'(FIFO_DEPTH - 2);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  typedef struct packed {
    logic parity;
    logic frame;
    logic overrun;
  } err_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 os_tick;
  logic [OSW-1:0]       os_q, os_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 armed_q, armed_d;
  err_t                 err_q, err_d;
  logic                 rts_q, rts_d;
  logic                 push, pop;
  logic                 mid_tick, ctr_tick;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign rx_s     = sync_q[1];
  assign div_eff  = (baud_div_i == '0) ? DIV_ONE : baud_div_i;
  assign os_tick  = (presc_q == div_eff - DIV_ONE);
  assign mid_tick = os_tick && (os_q == OS_HALF);
  assign ctr_tick = os_tick && (os_q == OS_LAST);
  assign pop      = !fifo_empty && rx_d_ready_i;

  always_comb begin
    state_d   = state_q;
    os_d      = os_tick ? os_q + OS_ONE : os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    armed_d   = (state_q == ST_IDLE) && (armed_q || rx_s);
    err_d     = '0;
    push      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A line held low (break) must go high once before a new start counts.
        if (armed_q && rx_enable_i && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        par_err_d = 1'b0;
        if (mid_tick) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (ctr_tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          os_d    = '0;
          if (bit_q == 3'd7) state_d = parity_en_i ? ST_PARITY : ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (ctr_tick) begin
          par_err_d = (rx_s != ^shift_q);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Finish at mid-stop so a back-to-back start edge is not missed.
        if (ctr_tick) begin
          state_d = ST_IDLE;
          if (!rx_s)                   err_d.frame = 1'b1;
          else if (par_err_q)          err_d.parity = 1'b1;
          else if (fifo_full && !pop)  err_d.overrun = !flush_i;
          else                         push = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_enable_i) begin
      state_d = ST_IDLE;
      err_d   = '0;
      push    = 1'b0;
    end

    if (state_d != state_q) os_d = '0;

    if (state_q == ST_IDLE && state_d != ST_IDLE) presc_d = '0;
    else if (os_tick)                             presc_d = '0;
    else                                          presc_d = presc_q + DIV_ONE;

    rts_d = !rx_enable_i || (fifo_count >= RTS_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b0;
      err_q     <= '0;
      rts_q     <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      state_q   <= state_d;
      presc_q   <= presc_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      armed_q   <= armed_d;
      err_q     <= err_d;
      rts_q     <= rts_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (push),
    .push_dat_i (shift_q),
    .pop_rdy_i  (rx_d_ready_i),
    .flush_i    (flush_i),
    .head_dat_o (rx_d_o),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rx_d_valid_o = !fifo_empty;
  assign rx_empty_o   = fifo_empty;
  assign rx_full_o    = fifo_full;
  assign rx_rts_n_o   = rts_q;
  assign parity_err_o = err_q.parity;
  assign frame_err_o  = err_q.frame;
  assign overrun_o    = err_q.overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level outcome model (queue FIFO + scheduled events) checked every cycle,
// plus literal expectations for latency, pulse counts and byte order.
module tb_uart_rx;
  localparam int OS    = 16;
  localparam int DEPTH = 8;
  localparam int DIVW  = 16;
  localparam int DIV   = 4;
  localparam int BIT   = OS * DIV;
  localparam int K_PUSH = 0, K_PAR = 1, K_FRM = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_i = 1'b1;
  logic            rx_enable_i = 1'b1;
  logic [DIVW-1:0] baud_div_i = DIVW'(DIV);
  logic            parity_en_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            rx_d_ready_i = 1'b0;
  logic            rx_rts_n_o;
  logic [7:0]      rx_d_o;
  logic            rx_d_valid_o, rx_full_o, rx_empty_o;
  logic            parity_err_o, frame_err_o, overrun_o;

  uart_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .rx_enable_i  (rx_enable_i),
    .baud_div_i   (baud_div_i),
    .parity_en_i  (parity_en_i),
    .flush_i      (flush_i),
    .rx_rts_n_o   (rx_rts_n_o),
    .rx_d_o       (rx_d_o),
    .rx_d_valid_o (rx_d_valid_o),
    .rx_d_ready_i (rx_d_ready_i),
    .rx_full_o    (rx_full_o),
    .rx_empty_o   (rx_empty_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         n_par = 0, n_frm = 0, n_ovr = 0;
  int         rise_cyc = -1;
  logic       prev_vld = 1'b0;
  logic       pend_pop = 1'b0, pend_flush = 1'b0, rts_pend = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: each frame resolves to one event at a cycle derived from the bit timing;
  // the FIFO is a queue updated by those events and by the consumer's pops.
  always @(negedge clk) begin
    ev_t        e;
    logic       push_now;
    logic [7:0] push_d;
    logic       exp_par, exp_frm, exp_ovr;
    if (!rst_n) begin
      evq.delete();
      mq.delete();
      pend_pop = 1'b0;
      pend_flush = 1'b0;
      rts_pend = 1'b1;
      chk("rst_empty", rx_empty_o, 1);
      chk("rst_valid", rx_d_valid_o, 0);
      chk("rst_full", rx_full_o, 0);
      chk("rst_data", rx_d_o, 0);
      chk("rst_rts", rx_rts_n_o, 1);
      chk("rst_pulses", {parity_err_o, frame_err_o, overrun_o}, 0);
    end else begin
      push_now = 1'b0;
      push_d = '0;
      exp_par = 1'b0;
      exp_frm = 1'b0;
      exp_ovr = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        if (e.kind == K_PUSH) begin
          push_now = 1'b1;
          push_d = e.d;
        end else if (e.kind == K_PAR) exp_par = 1'b1;
        else exp_frm = 1'b1;
      end
      if (pend_flush) begin
        mq.delete();
      end else begin
        if (push_now && mq.size() == DEPTH && !pend_pop) begin
          exp_ovr = 1'b1;
          push_now = 1'b0;
        end
        if (pend_pop && mq.size() > 0) void'(mq.pop_front());
        if (push_now) mq.push_back(push_d);
      end
      chk("cmp_valid", rx_d_valid_o, mq.size() > 0);
      chk("cmp_empty", rx_empty_o, mq.size() == 0);
      chk("cmp_full", rx_full_o, mq.size() == DEPTH);
      if (mq.size() > 0) chk("cmp_data", rx_d_o, mq[0]);
      chk("cmp_rts", rx_rts_n_o, rts_pend);
      chk("cmp_parity_err", parity_err_o, exp_par);
      chk("cmp_frame_err", frame_err_o, exp_frm);
      chk("cmp_overrun", overrun_o, exp_ovr);
      rts_pend = !rx_enable_i || (mq.size() >= DEPTH - 2);
      pend_pop = rx_d_ready_i && (mq.size() > 0);
      pend_flush = flush_i;
    end
    n_par += int'(parity_err_o);
    n_frm += int'(frame_err_o);
    n_ovr += int'(overrun_o);
    if (rx_d_valid_o && !prev_vld) rise_cyc = cyc;
    prev_vld = rx_d_valid_o;
  end

  task automatic bt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int hold_bits, output int n0);
    ev_t e;
    @(posedge clk);
    #1;
    n0 = cyc;
    // 2 sync flops + 1 detect cycle, half a bit to the start centre, then one bit per field.
    e.cyc = n0 + 3 + (OS / 2) * DIV + BIT * (9 + (parity_en_i ? 1 : 0));
    e.d = d;
    if (!sb) e.kind = K_FRM;
    else if (parity_en_i && (pb != ^d)) e.kind = K_PAR;
    else e.kind = K_PUSH;
    evq.push_back(e);
    rx_i = 1'b0;
    bt(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      bt(BIT);
    end
    if (parity_en_i) begin
      rx_i = pb;
      bt(BIT);
    end
    rx_i = sb;
    bt(BIT * (1 + hold_bits));
    rx_i = 1'b1;
    bt(32);
  endtask

  task automatic send_good(input logic [7:0] d);
    int n0;
    send_frame(d, ^d, 1'b1, 0, n0);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    bt(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      bt(BIT);
    end
    rx_i = d[nbits];
    bt(BIT / 2);
  endtask

  task automatic pop_one(input logic [7:0] exp);
    @(negedge clk);
    chk("pop_valid", rx_d_valid_o, 1);
    chk("pop_data", rx_d_o, exp);
    @(posedge clk);
    #1 rx_d_ready_i = 1'b1;
    @(posedge clk);
    #1 rx_d_ready_i = 1'b0;
  endtask

  initial begin
    int n0, p0, f0, o0, s0;
    repeat (3) @(negedge clk);
    chk("reset_rts_literal", rx_rts_n_o, 1);
    chk("reset_empty_literal", rx_empty_o, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bt(40);

    // 1: 0xA5, parity 0
    send_frame(8'hA5, 1'b0, 1'b1, 0, n0);
    chk("t1_latency", rise_cyc - n0, 675);
    chk("t1_data", rx_d_o, 8'hA5);
    chk("t1_no_errs", n_par + n_frm + n_ovr, 0);
    pop_one(8'hA5);

    // 2: parity mismatch, then correct parity
    p0 = n_par;
    send_frame(8'h01, 1'b0, 1'b1, 0, n0);
    chk("t2_parity_pulses", n_par - p0, 1);
    chk("t2_empty", rx_empty_o, 1);
    send_frame(8'h01, 1'b1, 1'b1, 0, n0);
    pop_one(8'h01);

    // 3: framing error followed by a 20-bit break
    f0 = n_frm;
    send_frame(8'h3C, 1'b0, 1'b0, 20, n0);
    chk("t3_frame_pulses", n_frm - f0, 1);
    chk("t3_empty", rx_empty_o, 1);
    send_good(8'h3C);
    pop_one(8'h3C);

    // 4: 3-tick glitch
    s0 = n_par + n_frm + n_ovr;
    @(posedge clk);
    #1 rx_i = 1'b0;
    bt(3 * DIV);
    rx_i = 1'b1;
    bt(2 * BIT);
    chk("t4_empty", rx_empty_o, 1);
    chk("t4_no_pulse", n_par + n_frm + n_ovr - s0, 0);

    // 5: fill past full with no consumer
    o0 = n_ovr;
    for (int i = 0; i < 9; i++) begin
      send_good(8'(8'h10 + i));
      if (i == 4) chk("t5_rts_at5", rx_rts_n_o, 0);
      if (i == 5) chk("t5_rts_at6", rx_rts_n_o, 1);
      if (i == 6) chk("t5_full_at7", rx_full_o, 0);
      if (i == 7) chk("t5_full_at8", rx_full_o, 1);
    end
    chk("t5_overrun_pulses", n_ovr - o0, 1);
    for (int i = 0; i < 8; i++) pop_one(8'(8'h10 + i));
    chk("t5_drained", rx_empty_o, 1);

    // flush drops buffered bytes
    send_good(8'h11);
    send_good(8'h22);
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_empty", rx_empty_o, 1);

    // 6a: reset mid-DATA with a byte buffered
    send_good(8'h33);
    send_partial(8'h00, 3);
    rst_n = 1'b0;
    rx_i = 1'b1;
    bt(10);
    chk("t6_rst_empty", rx_empty_o, 1);
    chk("t6_rst_valid", rx_d_valid_o, 0);
    chk("t6_rst_data", rx_d_o, 0);
    chk("t6_rst_rts", rx_rts_n_o, 1);
    rst_n = 1'b1;
    bt(40);
    send_good(8'h5A);

    // 6b: enable dropped mid-DATA keeps the FIFO and pushes nothing
    send_partial(8'h00, 3);
    rx_enable_i = 1'b0;
    bt(BIT);
    rx_i = 1'b1;
    bt(7 * BIT);
    chk("t6_dis_rts", rx_rts_n_o, 1);
    rx_enable_i = 1'b1;
    bt(40);
    pop_one(8'h5A);
    chk("t6_no_push", rx_empty_o, 1);
    send_good(8'h5A);
    pop_one(8'h5A);

    // parity disabled: shorter frame
    rx_enable_i = 1'b0;
    bt(4);
    parity_en_i = 1'b0;
    bt(4);
    rx_enable_i = 1'b1;
    bt(40);
    send_frame(8'h81, 1'b0, 1'b1, 0, n0);
    chk("nopar_latency", rise_cyc - n0, 611);
    pop_one(8'h81);

    bt(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the stage directly downstream of the UART transmitter.
- Deserialises a start / 8 data (LSB first) / optional parity / 1 stop frame from the serial line.
- Oversamples the line using an internal baud prescaler and buffers received bytes in a small first-word-fall-through FIFO.
- Drives RTS flow control back to the remote transmitter and reports parity, framing and overrun events as 1-cycle pulses for the irq block.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit; even, >=4.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, >=4.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial line; asynchronous to clk, idles high.
- rx_enable_i  in  1  receiver enable.
- baud_div_i  in  DIV_WIDTH  clk cycles per oversample tick; 0 is treated as 1.
- parity_en_i  in  1  1: a parity bit is expected after D7.
- flush_i  in  1  empties the FIFO.
- rx_rts_n_o  out  1  0 = the remote side may send.
- rx_d_o  out  8  FIFO head byte.
- rx_d_valid_o  out  1  FIFO not empty.
- rx_d_ready_i  in  1  consumer pops the head byte.
- rx_full_o  out  1  FIFO full.
- rx_empty_o  out  1  FIFO empty.
- parity_err_o  out  1  pulse: parity mismatch.
- frame_err_o  out  1  pulse: stop bit sampled low.
- overrun_o  out  1  pulse: good byte dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset rst_n. All flops reset asynchronously.
- Reset values:
  - Synchroniser flops = 1; FSM = IDLE; all counters = 0; FIFO empty.
  - rx_empty_o = 1; rx_full_o = 0; rx_d_valid_o = 0; rx_d_o = 0; rx_rts_n_o = 1; all error pulses = 0.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All decisions use rx_s.
- Prescaler:
  - Counts 0..max(baud_div_i,1)-1 and asserts os_tick for one cycle at the terminal count.
  - Free-running; cleared to 0 when the FSM leaves IDLE.
- Oversample counter: os_cnt advances on os_tick only; cleared on every FSM state change.
- FSM states and transitions:
  - IDLE:
    - A start is armed only after rx_s has been seen at 1 while in IDLE; this blocks a held-low break from retriggering.
    - Armed, rx_enable_i = 1 and rx_s = 0 -> START.
  - START:
    - On the tick where os_cnt = OVERSAMPLE/2-1, sample rx_s.
    - Sample = 1 (false start / glitch) -> IDLE, nothing reported.
    - Sample = 0 -> DATA, bit_cnt = 0.
  - DATA:
    - Sample rx_s every OVERSAMPLE ticks, i.e. at bit centre.
    - Shift the sample in at the MSB of the shift register so that LSB-first order is preserved.
    - After bit_cnt = 7: go to PARITY if parity_en_i, else STOP.
  - PARITY:
    - Sample at centre.
    - Expected bit = XOR of D0..D7, i.e. even parity over data plus parity bit.
    - Latch the mismatch flag; go to STOP.
  - STOP: sample at centre, then go to IDLE in the same cycle. Completion is at mid-stop so the next start edge is not missed.
- Stop-sample resolution, in priority order:
  - stop = 0 -> frame_err_o pulse; byte discarded.
  - else parity mismatch -> parity_err_o pulse; byte discarded.
  - else FIFO full and no pop this cycle -> overrun_o pulse; byte discarded.
  - else byte pushed.
  - Pulses are registered and fire the cycle after the stop-sample tick.
  - A pushed byte appears on rx_d_valid_o the cycle after the stop-sample tick.
- Enable and configuration changes:
  - rx_enable_i = 0 aborts any frame-in-progress: FSM -> IDLE next cycle, no push, no pulses.
  - The FIFO contents are kept.
  - parity_en_i and baud_div_i are sampled live; software changes them only while disabled.
- FIFO:
  - First-word-fall-through: rx_d_o = head; pop on rx_d_valid_o && rx_d_ready_i.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Pop and push in the same cycle when full: both occur, no overrun.
  - Pop when empty is ignored.
  - flush_i empties the FIFO next cycle and overrides push and pop. If a push coincides with flush_i, the byte is dropped silently.
- RTS:
  - rx_rts_n_o is registered.
  - rx_rts_n_o = 1 when rx_enable_i = 0 or FIFO count >= FIFO_DEPTH-2 (2-entry headroom for in-flight bytes).
  - Otherwise rx_rts_n_o = 0.
- Status: rx_full_o and rx_empty_o are derived from the registered pointers.

Test Plan:
1. baud_div_i = 4, OVERSAMPLE = 16 (64 clk per bit), parity on; send 0xA5 with parity bit 0 and stop 1 -> rx_d_o = 0xA5, rx_d_valid_o = 1 the cycle after the stop-sample tick, no error pulses.
2. Send 0x01 with parity bit 0 (expected 1) -> single parity_err_o pulse, FIFO stays empty. Then send 0x01 with parity bit 1 -> byte accepted.
3. Send 0x3C with stop bit 0, line held low for 20 bit times, then released -> exactly one frame_err_o pulse, no retrigger while low. Next 0x3C is received correctly.
4. Low glitch of 3 os ticks on an idle line -> FSM returns to IDLE from START; no push, no pulse.
5. Send 9 bytes 0x10..0x18 with rx_d_ready_i = 0 -> rx_rts_n_o rises once count reaches 6, rx_full_o after the 8th byte, overrun_o pulses on 0x18. Drain -> order 0x10..0x17.
6. Reset asserted mid-DATA, and rx_enable_i dropped mid-DATA in a separate run -> all outputs at their reset values / no push. The next full frame 0x5A is received cleanly.
